asp_irq_ctrl: RTL and testbench
===============================

Name: asp_irq_ctrl

Overview:
- Interrupt aggregation stage between the ASP interrupt sources (DMA_0, kernel, DMA_1) and the host interrupt interface.
- Captures source rising edges into sticky pending bits and gates them with a CSR enable mask.
- Dispatches one host interrupt message at a time using a valid/ready handshake; the host rearms a line by clearing its pending bit over the MMIO64 AVMM CSR port.

Parameters:
- NUM_IRQ_IN, 3 (ASP_AVMM_NUM_IRQ_USED): number of source lines; bit index matches ASP_*_IRQ_BIT.
- NUM_HOST_IRQ, 4 (ASP_NUM_INTERRUPT_LINES): host vector space; NUM_IRQ_IN <= NUM_HOST_IRQ.
- CSR_ADDR_WIDTH, 3: word address width of the CSR port (64-bit words).
- CNT_WIDTH, 32: width of the dispatch counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- irq_in  in  NUM_IRQ_IN  level sources; bit0 DMA_0, bit1 kernel, bit2 DMA_1
- csr_address  in  CSR_ADDR_WIDTH  word address
- csr_read  in  1  read strobe
- csr_write  in  1  write strobe
- csr_writedata  in  64  write data
- csr_byteenable  in  8  byte enables
- csr_readdata  out  64  read data
- csr_readdatavalid  out  1  read response strobe
- csr_waitrequest  out  1  constant 0
- irq_valid  out  1  host interrupt request
- irq_vector  out  $clog2(NUM_HOST_IRQ)  line number of the request
- irq_ready  in  1  host accepts the request

Behaviour:
- Reset: async assert, sync-style release. All of the following clear to 0: outputs, pending, enable, in_flight, irq_prev, count, rr_ptr. The FSM returns to IDLE. An active request drops immediately and is not replayed.
- Edge capture: irq_prev is registered irq_in. rise = irq_in & ~irq_prev. pending[i] sets on rise[i] regardless of enable.
- Source held high across reset: the first cycle after release counts as a rise because irq_prev = 0.
- CSR map (word address; 1-cycle read latency; readdatavalid pulses the cycle after csr_read; unmapped reads return 0; unmapped writes ignored):
  - 0 STATUS RO: [NUM_IRQ_IN-1:0] pending, [NUM_IRQ_IN+7:8] in_flight.
  - 1 ENABLE RW: [NUM_IRQ_IN-1:0]; written only when byteenable[0]=1; reset 0.
  - 2 CLEAR W1C: writing 1 to bit i clears pending[i] and in_flight[i] when byteenable[0]=1. Reads return 0.
  - 3 COUNT: returns count zero-extended. Any write clears count.
- Set/clear collision: rise[i] and a CLEAR of bit i in the same cycle leave pending[i]=1 and in_flight[i]=0.
- Candidate vector: cand = pending & enable & ~in_flight.
- FSM:
  - IDLE:
    - If cand != 0, grant the first set bit at or after rr_ptr, searching upward with wrap.
    - Latch irq_vector = grant index, assert irq_valid next cycle, go to REQ.
  - REQ:
    - irq_valid and irq_vector stay stable until irq_ready.
    - A disable or CLEAR of the granted line during REQ does not withdraw the request.
    - On the cycle with irq_valid & irq_ready: set in_flight[grant], increment count, set rr_ptr = grant+1 mod NUM_IRQ_IN, return to IDLE.
    - If that same cycle carries a CLEAR of the granted line, the in_flight set wins.
  - Throughput: minimum one IDLE cycle between requests, so at most one request every 2 cycles.
- A line is re-dispatched only after the host clears it (CLEAR) and a new rise occurs. A rise while in_flight only keeps pending set.
- count wraps at 2^CNT_WIDTH.
- Simultaneous csr_read and csr_write: both execute; the read returns the pre-write value.

Decomposition:
- ofs_asp_pkg holds:
  - CSR word offsets: ASP_IRQ_CSR_STATUS=0, ENABLE=1, CLEAR=2, COUNT=3.
  - FSM enum t_irq_ctrl_state {IRQ_IDLE, IRQ_REQ}.
  - Existing ASP_*_IRQ_BIT and line-count parameters.
- One sub-module: asp_irq_rr_arb. It is combinational round-robin first-set-bit search taking cand and rr_ptr, and producing grant index and grant valid.

Test Plan:
- Reset, then ENABLE=0x7. Pulse irq_in[1] for 1 cycle -> STATUS=0x002. irq_valid rises 2 cycles after the rise with irq_vector=1. irq_ready=1 -> STATUS=0x202, COUNT=1.
- Hold irq_ready=0 for 10 cycles during REQ, then write ENABLE=0 -> irq_valid and irq_vector remain stable. Release ready -> exactly one handshake, COUNT=1.
- Rise all three lines in one cycle with ready=1 -> vectors dispatched in order 0,1,2 at cycles t+2, t+4, t+6. With rr_ptr=2 preset via a prior line-1 grant, order is 2,0,1.
- Line 0 in_flight, second rise on irq_in[0] -> no new request. Write CLEAR=0x1 -> STATUS bit0=0. A new rise then dispatches again, COUNT increments.
- Same-cycle rise[2] and CLEAR bit2 -> STATUS reads 0x004 and the line is dispatchable. Read of address 5 -> readdata=0 with readdatavalid one cycle after csr_read.
- Assert reset_n=0 mid-REQ -> irq_valid=0 the same cycle (asynchronous) and all CSRs=0. With irq_in[0] held high, the first cycle after release captures pending[0]=1.

Source files
------------

// File: rtl/ofs_asp_pkg.sv
// Shared ASP definitions: interrupt source bit positions, line counts,
// interrupt CSR word offsets and the dispatch FSM state type.
package ofs_asp_pkg;

    localparam int ASP_DMA_0_IRQ_BIT       = 0;
    localparam int ASP_KERNEL_IRQ_BIT      = 1;
    localparam int ASP_DMA_1_IRQ_BIT       = 2;
    localparam int ASP_AVMM_NUM_IRQ_USED   = 3;
    localparam int ASP_NUM_INTERRUPT_LINES = 4;

    localparam int ASP_IRQ_CSR_STATUS = 0;
    localparam int ASP_IRQ_CSR_ENABLE = 1;
    localparam int ASP_IRQ_CSR_CLEAR  = 2;
    localparam int ASP_IRQ_CSR_COUNT  = 3;

    typedef enum logic [0:0] {
        IRQ_IDLE = 1'b0,
        IRQ_REQ  = 1'b1
    } t_irq_ctrl_state;

endpackage

// File: rtl/asp_irq_rr_arb.sv
// Combinational round-robin arbiter: returns the first set candidate bit
// at or above rr_ptr, wrapping around to bit 0.
module asp_irq_rr_arb #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  cand,
    input  logic [PW-1:0] rr_ptr,
    output logic [PW-1:0] grant_idx,
    output logic          grant_vld
);

    logic [PW-1:0] idx;

    always_comb begin
        idx       = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(rr_ptr) + off) % N);
            if (!grant_vld && cand[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/asp_irq_ctrl.sv
// ASP interrupt aggregation: sticky edge capture, CSR enable/clear, and
// one-at-a-time round-robin dispatch of host interrupt messages.
module asp_irq_ctrl
    import ofs_asp_pkg::*;
#(
    parameter int NUM_IRQ_IN     = ASP_AVMM_NUM_IRQ_USED,
    parameter int NUM_HOST_IRQ   = ASP_NUM_INTERRUPT_LINES,
    parameter int CSR_ADDR_WIDTH = 3,
    parameter int CNT_WIDTH      = 32,
    localparam int VEC_W         = $clog2(NUM_HOST_IRQ),
    localparam int PTR_W         = (NUM_IRQ_IN > 1) ? $clog2(NUM_IRQ_IN) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_IRQ_IN-1:0]     irq_in,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_address,
    input  logic                      csr_read,
    input  logic                      csr_write,
    input  logic [63:0]               csr_writedata,
    input  logic [7:0]                csr_byteenable,
    output logic [63:0]               csr_readdata,
    output logic                      csr_readdatavalid,
    output logic                      csr_waitrequest,
    output logic                      irq_valid,
    output logic [VEC_W-1:0]          irq_vector,
    input  logic                      irq_ready
);

    logic [NUM_IRQ_IN-1:0] irq_prev_q, irq_prev_d;
    logic [NUM_IRQ_IN-1:0] pending_q, pending_d;
    logic [NUM_IRQ_IN-1:0] enable_q, enable_d;
    logic [NUM_IRQ_IN-1:0] in_flight_q, in_flight_d;
    logic [NUM_IRQ_IN-1:0] rise, clr_mask, cand;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      gnt_q, gnt_d;
    logic [PTR_W-1:0]      arb_idx;
    logic                  arb_vld;
    t_irq_ctrl_state       state_q, state_d;
    logic                  irq_valid_q, irq_valid_d;
    logic [VEC_W-1:0]      irq_vector_q, irq_vector_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [63:0]           readdata_q, readdata_d;
    logic                  readdatavalid_q, readdatavalid_d;
    logic                  hs;
    logic                  wr_enable, wr_clear, wr_count;
    logic                  unused_csr_bits;

    assign unused_csr_bits = ^{csr_writedata[63:NUM_IRQ_IN], csr_byteenable[7:1]};

    assign wr_enable = csr_write && (int'(csr_address) == ASP_IRQ_CSR_ENABLE) && csr_byteenable[0];
    assign wr_clear  = csr_write && (int'(csr_address) == ASP_IRQ_CSR_CLEAR) && csr_byteenable[0];
    assign wr_count  = csr_write && (int'(csr_address) == ASP_IRQ_CSR_COUNT);

    assign hs   = (state_q == IRQ_REQ) && irq_ready;
    assign cand = pending_q & enable_q & ~in_flight_q;

    asp_irq_rr_arb #(
        .N  (NUM_IRQ_IN),
        .PW (PTR_W)
    ) u_arb (
        .cand      (cand),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // Pending/in-flight bookkeeping: a rise beats a same-cycle clear on
    // pending, and a handshake beats a same-cycle clear on in_flight.
    always_comb begin
        irq_prev_d  = irq_in;
        rise        = irq_in & ~irq_prev_q;
        clr_mask    = wr_clear ? csr_writedata[NUM_IRQ_IN-1:0] : '0;
        pending_d   = (pending_q & ~clr_mask) | rise;
        in_flight_d = in_flight_q & ~clr_mask;
        if (hs) begin
            in_flight_d[gnt_q] = 1'b1;
        end
        enable_d = wr_enable ? csr_writedata[NUM_IRQ_IN-1:0] : enable_q;
        count_d  = count_q;
        if (hs) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
        if (wr_count) begin
            count_d = '0;
        end
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (int'(gnt_q) == NUM_IRQ_IN - 1) ? '0 : gnt_q + PTR_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        irq_valid_d  = irq_valid_q;
        irq_vector_d = irq_vector_q;
        gnt_d        = gnt_q;
        case (state_q)
            IRQ_IDLE: begin
                if (arb_vld) begin
                    state_d      = IRQ_REQ;
                    irq_valid_d  = 1'b1;
                    irq_vector_d = VEC_W'(arb_idx);
                    gnt_d        = arb_idx;
                end
            end
            IRQ_REQ: begin
                // The request is committed once raised; enable/clear changes do not retract it.
                if (irq_ready) begin
                    state_d     = IRQ_IDLE;
                    irq_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IRQ_IDLE;
                irq_valid_d = 1'b0;
            end
        endcase
    end

    // Readback samples pre-write state, so a same-cycle write is not visible.
    always_comb begin
        readdata_d      = '0;
        readdatavalid_d = csr_read;
        if (csr_read) begin
            case (int'(csr_address))
                ASP_IRQ_CSR_STATUS: begin
                    readdata_d[NUM_IRQ_IN-1:0]   = pending_q;
                    readdata_d[NUM_IRQ_IN+7:8]   = in_flight_q;
                end
                ASP_IRQ_CSR_ENABLE: readdata_d[NUM_IRQ_IN-1:0] = enable_q;
                ASP_IRQ_CSR_COUNT:  readdata_d[CNT_WIDTH-1:0]  = count_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_prev_q      <= '0;
            pending_q       <= '0;
            enable_q        <= '0;
            in_flight_q     <= '0;
            rr_ptr_q        <= '0;
            gnt_q           <= '0;
            state_q         <= IRQ_IDLE;
            irq_valid_q     <= 1'b0;
            irq_vector_q    <= '0;
            count_q         <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            irq_prev_q      <= irq_prev_d;
            pending_q       <= pending_d;
            enable_q        <= enable_d;
            in_flight_q     <= in_flight_d;
            rr_ptr_q        <= rr_ptr_d;
            gnt_q           <= gnt_d;
            state_q         <= state_d;
            irq_valid_q     <= irq_valid_d;
            irq_vector_q    <= irq_vector_d;
            count_q         <= count_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

    assign csr_readdata      = readdata_q;
    assign csr_readdatavalid = readdatavalid_q;
    assign csr_waitrequest   = 1'b0;
    assign irq_valid         = irq_valid_q;
    assign irq_vector        = irq_vector_q;

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Bench for asp_irq_ctrl: directed scenarios plus a randomized run checked
// cycle by cycle against a behavioural model of the interrupt controller.
module tb_asp_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  irq_in;
    logic [2:0]  csr_address;
    logic        csr_read;
    logic        csr_write;
    logic [63:0] csr_writedata;
    logic [7:0]  csr_byteenable;
    logic [63:0] csr_readdata;
    logic        csr_readdatavalid;
    logic        csr_waitrequest;
    logic        irq_valid;
    logic [1:0]  irq_vector;
    logic        irq_ready;

    int total = 0;
    int bad   = 0;

    bit [2:0]  m_pend, m_en, m_inf, m_prev;
    bit        m_req, m_rdv;
    int        m_vec, m_ptr;
    bit [31:0] m_cnt;
    bit [63:0] m_rd;

    always #5 clk = ~clk;

    asp_irq_ctrl dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .irq_in            (irq_in),
        .csr_address       (csr_address),
        .csr_read          (csr_read),
        .csr_write         (csr_write),
        .csr_writedata     (csr_writedata),
        .csr_byteenable    (csr_byteenable),
        .csr_readdata      (csr_readdata),
        .csr_readdatavalid (csr_readdatavalid),
        .csr_waitrequest   (csr_waitrequest),
        .irq_valid         (irq_valid),
        .irq_vector        (irq_vector),
        .irq_ready         (irq_ready)
    );

    task automatic model_reset();
        m_pend = '0; m_en = '0; m_inf = '0; m_prev = '0;
        m_req = 1'b0; m_rdv = 1'b0; m_vec = 0; m_ptr = 0; m_cnt = '0; m_rd = '0;
    endtask

    // One clock of the controller's rules applied to the currently driven inputs.
    task automatic model_step();
        bit [2:0] cand, rise, clr;
        int g;
        bit hs;
        cand = m_pend & m_en & ~m_inf;
        g = -1;
        for (int off = 0; off < 3; off++) begin
            int idx;
            idx = (m_ptr + off) % 3;
            if (g < 0 && ((cand >> idx) & 3'b001) != 3'b000) g = idx;
        end
        hs   = m_req && (irq_ready === 1'b1);
        rise = irq_in & ~m_prev;
        clr  = (csr_write && csr_address == 3'd2 && csr_byteenable[0]) ? csr_writedata[2:0] : 3'b000;
        m_rdv = csr_read;
        m_rd  = '0;
        if (csr_read) begin
            if (csr_address == 3'd0)      m_rd = {53'b0, m_inf, 5'b0, m_pend};
            else if (csr_address == 3'd1) m_rd = {61'b0, m_en};
            else if (csr_address == 3'd3) m_rd = {32'b0, m_cnt};
        end
        m_pend = (m_pend & ~clr) | rise;
        m_inf  = m_inf & ~clr;
        if (hs) begin
            m_inf = m_inf | 3'(1 << m_vec);
            m_cnt = m_cnt + 1;
            m_ptr = (m_vec + 1) % 3;
            m_req = 1'b0;
        end else if (!m_req && g >= 0) begin
            m_req = 1'b1;
            m_vec = g;
        end
        if (csr_write && csr_address == 3'd1 && csr_byteenable[0]) m_en = csr_writedata[2:0];
        if (csr_write && csr_address == 3'd3) m_cnt = '0;
        m_prev = irq_in;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        irq_in = '0; csr_read = 1'b0; csr_write = 1'b0; csr_address = '0;
        csr_writedata = '0; csr_byteenable = '0; irq_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic csr_wr(input logic [2:0] addr, input logic [63:0] data);
        csr_write = 1'b1; csr_address = addr; csr_writedata = data; csr_byteenable = 8'hFF;
        cycle();
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [2:0] addr, output logic [63:0] d, output logic v);
        csr_read = 1'b1; csr_address = addr;
        cycle();
        csr_read = 1'b0;
        d = csr_readdata;
        v = csr_readdatavalid;
    endtask

    task automatic pulse(input logic [2:0] bits);
        irq_in = bits;
        cycle();
        irq_in = '0;
    endtask

    task automatic test_reset();
        logic [63:0] d;
        logic v;
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", irq_valid); end
        total++; if (irq_vector !== 2'd0) begin bad++; $display("FAIL reset_vector got=%0d want=0", irq_vector); end
        total++; if (csr_readdatavalid !== 1'b0) begin bad++; $display("FAIL reset_rdv got=%b want=0", csr_readdatavalid); end
        total++; if (csr_readdata !== 64'd0) begin bad++; $display("FAIL reset_rdata got=%h want=0", csr_readdata); end
        total++; if (csr_waitrequest !== 1'b0) begin bad++; $display("FAIL waitrequest got=%b want=0", csr_waitrequest); end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            csr_rd(3'(a), d, v);
            total++; if (v !== 1'b1 || d !== 64'd0) begin bad++; $display("FAIL reset_csr%0d got=%h/%b want=0/1", a, d, v); end
        end
    endtask

    task automatic test_single();
        logic [63:0] d;
        logic v;
        do_reset();
        csr_wr(3'd1, 64'h7);
        pulse(3'b010);
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", irq_valid); end
        cycle();
        total++; if (irq_valid !== 1'b1 || irq_vector !== 2'd1) begin bad++; $display("FAIL single_req got=%b/%0d want=1/1", irq_valid, irq_vector); end
        csr_rd(3'd0, d, v);
        total++; if (v !== 1'b1 || d !== 64'h2) begin bad++; $display("FAIL single_status got=%h/%b want=2/1", d, v); end
        irq_ready = 1'b1;
        cycle();
        irq_ready = 1'b0;
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL single_drop got=%b want=0", irq_valid); end
        csr_rd(3'd0, d, v);
        total++; if (d !== 64'h202) begin bad++; $display("FAIL single_status2 got=%h want=202", d); end
        csr_rd(3'd3, d, v);
        total++; if (d !== 64'd1) begin bad++; $display("FAIL single_count got=%0d want=1", d); end
    endtask

    task automatic test_hold();
        logic [63:0] d;
        logic v;
        do_reset();
        csr_wr(3'd1, 64'h7);
        pulse(3'b001);
        cycle();
        for (int k = 0; k < 10; k++) begin
            cycle();
            total++; if (irq_valid !== 1'b1 || irq_vector !== 2'd0) begin bad++; $display("FAIL hold_stable%0d got=%b/%0d want=1/0", k, irq_valid, irq_vector); end
        end
        csr_wr(3'd1, 64'h0);
        total++; if (irq_valid !== 1'b1 || irq_vector !== 2'd0) begin bad++; $display("FAIL hold_disable got=%b/%0d want=1/0", irq_valid, irq_vector); end
        irq_ready = 1'b1;
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL hold_after%0d got=%b want=0", k, irq_valid); end
        end
        irq_ready = 1'b0;
        csr_rd(3'd3, d, v);
        total++; if (d !== 64'd1) begin bad++; $display("FAIL hold_count got=%0d want=1", d); end
    endtask

    task automatic test_order();
        int first;
        bit exp_v;
        do_reset();
        csr_wr(3'd1, 64'h7);
        irq_ready = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            first = (pass == 0) ? 0 : 2;
            irq_in = 3'b111;
            for (int k = 1; k <= 8; k++) begin
                cycle();
                irq_in = '0;
                exp_v = (k == 2 || k == 4 || k == 6);
                total++; if (irq_valid !== exp_v) begin bad++; $display("FAIL order%0d_valid k=%0d got=%b want=%b", pass, k, irq_valid, exp_v); end
                if (exp_v) begin
                    total++;
                    if (irq_vector !== 2'((first + k / 2 - 1) % 3)) begin
                        bad++; $display("FAIL order%0d_vec k=%0d got=%0d want=%0d", pass, k, irq_vector, (first + k / 2 - 1) % 3);
                    end
                end
            end
            if (pass == 0) begin
                csr_wr(3'd2, 64'h7);
                pulse(3'b010);
                cycle();
                total++; if (irq_valid !== 1'b1 || irq_vector !== 2'd1) begin bad++; $display("FAIL order_pre got=%b/%0d want=1/1", irq_valid, irq_vector); end
                cycle();
                csr_wr(3'd2, 64'h2);
            end
        end
        irq_ready = 1'b0;
    endtask

    task automatic test_rearm();
        logic [63:0] d;
        logic v;
        do_reset();
        csr_wr(3'd1, 64'h1);
        irq_ready = 1'b1;
        pulse(3'b001);
        cycle();
        total++; if (irq_valid !== 1'b1 || irq_vector !== 2'd0) begin bad++; $display("FAIL rearm_first got=%b/%0d want=1/0", irq_valid, irq_vector); end
        cycle();
        pulse(3'b001);
        for (int k = 0; k < 5; k++) begin
            cycle();
            total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL rearm_inflight%0d got=%b want=0", k, irq_valid); end
        end
        csr_rd(3'd0, d, v);
        total++; if (d !== 64'h101) begin bad++; $display("FAIL rearm_status got=%h want=101", d); end
        csr_wr(3'd2, 64'h1);
        csr_rd(3'd0, d, v);
        total++; if (d[0] !== 1'b0 || d !== 64'h0) begin bad++; $display("FAIL rearm_cleared got=%h want=0", d); end
        pulse(3'b001);
        cycle();
        total++; if (irq_valid !== 1'b1 || irq_vector !== 2'd0) begin bad++; $display("FAIL rearm_again got=%b/%0d want=1/0", irq_valid, irq_vector); end
        cycle();
        irq_ready = 1'b0;
        csr_rd(3'd3, d, v);
        total++; if (d !== 64'd2) begin bad++; $display("FAIL rearm_count got=%0d want=2", d); end
    endtask

    task automatic test_collision();
        logic [63:0] d;
        logic v;
        do_reset();
        csr_wr(3'd1, 64'h4);
        irq_ready = 1'b1;
        pulse(3'b100);
        cycle();
        cycle();
        irq_ready = 1'b0;
        irq_in = 3'b100;
        csr_write = 1'b1; csr_address = 3'd2; csr_writedata = 64'h4; csr_byteenable = 8'hFF;
        cycle();
        csr_write = 1'b0; irq_in = '0;
        csr_rd(3'd0, d, v);
        total++; if (d !== 64'h004) begin bad++; $display("FAIL coll_status got=%h want=004", d); end
        total++; if (irq_valid !== 1'b1 || irq_vector !== 2'd2) begin bad++; $display("FAIL coll_redispatch got=%b/%0d want=1/2", irq_valid, irq_vector); end
        csr_read = 1'b1; csr_write = 1'b1; csr_address = 3'd1; csr_writedata = 64'h0;
        cycle();
        csr_read = 1'b0; csr_write = 1'b0;
        total++; if (csr_readdatavalid !== 1'b1 || csr_readdata !== 64'h4) begin bad++; $display("FAIL rw_same got=%h/%b want=4/1", csr_readdata, csr_readdatavalid); end
        csr_rd(3'd1, d, v);
        total++; if (d !== 64'h0) begin bad++; $display("FAIL rw_after got=%h want=0", d); end
        csr_byteenable = 8'hFF;
        csr_rd(3'd5, d, v);
        total++; if (v !== 1'b1 || d !== 64'h0) begin bad++; $display("FAIL unmapped got=%h/%b want=0/1", d, v); end
        cycle();
        total++; if (csr_readdatavalid !== 1'b0) begin bad++; $display("FAIL rdv_pulse got=%b want=0", csr_readdatavalid); end
    endtask

    task automatic test_async_reset();
        logic [63:0] d;
        logic v;
        do_reset();
        csr_wr(3'd1, 64'h1);
        pulse(3'b001);
        cycle();
        total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL areset_pre got=%b want=1", irq_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (irq_valid !== 1'b0 || irq_vector !== 2'd0) begin bad++; $display("FAIL areset_drop got=%b/%0d want=0/0", irq_valid, irq_vector); end
        model_reset();
        irq_in = 3'b001;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        csr_rd(3'd1, d, v);
        total++; if (d !== 64'h0) begin bad++; $display("FAIL areset_enable got=%h want=0", d); end
        csr_rd(3'd0, d, v);
        total++; if (d !== 64'h001) begin bad++; $display("FAIL areset_capture got=%h want=001", d); end
        csr_rd(3'd3, d, v);
        total++; if (d !== 64'h0) begin bad++; $display("FAIL areset_count got=%h want=0", d); end
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL areset_noreq got=%b want=0", irq_valid); end
        irq_in = '0;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        csr_wr(3'd1, 64'h7);
        for (int n = 0; n < 800; n++) begin
            irq_in    = irq_in ^ 3'($urandom_range(0, 7) & $urandom_range(0, 7));
            irq_ready = ($urandom_range(0, 3) != 0);
            csr_read  = 1'b0;
            csr_write = 1'b0;
            r = $urandom_range(0, 9);
            csr_address = 3'($urandom_range(0, 7));
            if (r < 3) csr_read = 1'b1;
            if (r >= 2 && r < 5) begin
                csr_write      = 1'b1;
                csr_writedata  = {$urandom, $urandom};
                csr_byteenable = 8'($urandom);
                if (csr_address == 3'd3 && m_req && irq_ready) csr_address = 3'd1;
                if (csr_address == 3'd1 && $urandom_range(0, 1) == 1) csr_writedata[2:0] = 3'b111;
            end
            cycle();
            total++; if (irq_valid !== m_req) begin bad++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, irq_valid, m_req); end
            if (m_req) begin
                total++; if (irq_vector !== 2'(m_vec)) begin bad++; $display("FAIL rnd_vec n=%0d got=%0d want=%0d", n, irq_vector, m_vec); end
            end
            total++; if (csr_readdatavalid !== m_rdv) begin bad++; $display("FAIL rnd_rdv n=%0d got=%b want=%b", n, csr_readdatavalid, m_rdv); end
            if (m_rdv) begin
                total++; if (csr_readdata !== m_rd) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h want=%h", n, csr_readdata, m_rd); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_order();
        test_rearm();
        test_collision();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
